// File: rtl/fetch_unit_if.sv
// Fetch unit boundary: branch-logic feedback, instruction-memory
// read port, decode handshake and trap reporting.
interface fetch_unit_if;
   logic [31:0] next_pc;
   logic        msl;
   logic [31:0] pc;
   logic        hold;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        trap;
   logic [1:0]  trap_cause;
   logic [31:0] trap_pc;

   modport master (
      input  next_pc, msl, imem_ack, imem_rdata, instr_ready,
      output pc, hold, imem_req, imem_addr,
      output instr, instr_valid, trap, trap_cause, trap_pc
   );

   modport slave (
      output next_pc, msl, imem_ack, imem_rdata, instr_ready,
      input  pc, hold, imem_req, imem_addr,
      input  instr, instr_valid, trap, trap_cause, trap_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, runs the imem read handshake and
// presents instructions to decode; traps on bad target or timeout.
module fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
   parameter int unsigned ACK_TIMEOUT  = 16,
   parameter int unsigned CNT_W        = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   fetch_unit_if.master bus
);

   localparam int unsigned TO_M1 =
      (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TO_M1);
   localparam logic TO_EN = (ACK_TIMEOUT > 0);
   localparam logic [31:0] BUBBLE_PC = RESET_VECTOR - 32'd4;

   typedef enum logic [1:0] {
      S_ISSUE = 2'd0,
      S_REQ   = 2'd1,
      S_TRAP  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]  cause_q, cause_d;
   logic [31:0] tpc_q, tpc_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_ISSUE;
         pc_q    <= BUBBLE_PC;
         instr_q <= NOP_INSTR;
         cnt_q   <= '0;
         cause_q <= 2'b00;
         tpc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
         tpc_q   <= tpc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      tpc_d   = tpc_q;
      unique case (state_q)
         S_ISSUE: begin
            if (bus.instr_ready) begin
               if (bus.msl) begin
                  state_d = S_TRAP;
                  cause_d = 2'b01;
                  tpc_d   = bus.next_pc;
               end else begin
                  state_d = S_REQ;
                  pc_d    = bus.next_pc;
               end
            end
         end
         S_REQ: begin
            // ACK beats a timeout landing in the same cycle
            if (bus.imem_ack) begin
               state_d = S_ISSUE;
               instr_d = bus.imem_rdata;
               cnt_d   = '0;
            end else begin
               if (TO_EN && cnt_q == TO_LIM) begin
                  state_d = S_TRAP;
                  cause_d = 2'b10;
                  tpc_d   = pc_q;
               end
               if (cnt_q != '1) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_ISSUE;
         end
      endcase
   end

   always_comb begin
      bus.hold        = 1'b1;
      bus.imem_req    = 1'b0;
      bus.instr_valid = 1'b0;
      bus.trap        = 1'b0;
      unique case (state_q)
         S_ISSUE: begin
            bus.hold        = ~bus.instr_ready;
            bus.instr_valid = 1'b1;
         end
         S_REQ: begin
            bus.imem_req = 1'b1;
         end
         S_TRAP: begin
            bus.trap = 1'b1;
         end
         default: begin
            bus.hold = 1'b1;
         end
      endcase
   end

   assign bus.pc         = pc_q;
   assign bus.imem_addr  = pc_q;
   assign bus.instr      = instr_q;
   assign bus.trap_cause = cause_q;
   assign bus.trap_pc    = tpc_q;

endmodule
